axis_sink_checker: RTL and testbench
====================================

Name: axis_sink_checker

Overview:
- AXI-Stream receiving endpoint. Consumes beats from an upstream stream source, applies a programmable backpressure pattern on tready, and checks that the data forms an incrementing sequence.
- Reports beat count, mismatch count, a sticky error flag and the first offending word.
- Sits at the far end of the stream in bring-up and loopback benches, and as a self-check block in FPGA test designs.

Parameters:
- AXIS_WIDTH, 32, width of s_axis_tdata and the data/expected registers.
- CNT_WIDTH, 16, width of the beat and error counters (saturating).
- PAT_WIDTH, 8, length of the tready backpressure pattern in cycles.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; low returns the block to IDLE.
- clr  input  1  synchronous clear of counters, error flag and first_err_data.
- ready_pattern  input  PAT_WIDTH  backpressure pattern; bit i = tready in cycle i of the rotation.
- s_axis_tvalid  input  1  upstream valid.
- s_axis_tdata  input  AXIS_WIDTH  upstream data.
- s_axis_tready  output  1  registered ready.
- beat_count  output  CNT_WIDTH  accepted beats since reset/clr.
- err_count  output  CNT_WIDTH  sequence mismatches since reset/clr.
- error  output  1  sticky; set on first mismatch.
- first_err_data  output  AXIS_WIDTH  tdata of the first mismatching beat.
- last_data  output  AXIS_WIDTH  tdata of the most recent accepted beat.
- locked  output  1  high in CHECK state.

Behaviour:
- Reset (reset_n low, async): state=IDLE. tready, error and locked = 0. All counters and data registers = 0. Pattern register = 0.
- Handshake: hs = s_axis_tvalid & s_axis_tready. tdata is sampled only on hs. The block never depends on tvalid to raise tready.
- States:
  - IDLE: tready=0. en=1 moves to ARMED; on that transition pat_q <= ready_pattern, and 0 is replaced by all-ones to prevent deadlock.
  - ARMED: waits for the first hs. On hs: expected <= tdata+1, last_data <= tdata, beat_count++, go to CHECK. No compare on this beat.
  - CHECK: on hs, compare tdata with expected.
    - Match: no error action.
    - Mismatch: err_count++. If error==0, then first_err_data <= tdata and error <= 1.
    - Both cases: expected <= tdata+1 (resync after error), last_data <= tdata, beat_count++.
  - en=0 in ARMED or CHECK: go to IDLE next cycle. expected and counters are retained.
- tready generation:
  - Registered. In ARMED/CHECK: tready_q <= pat_q[0] and pat_q rotates right one position every cycle, independent of tvalid.
  - Entering ARMED: first tready=1 occurs at the earliest 1 cycle after en rises.
  - Leaving to IDLE: tready_q <= 0 in the same update. A handshake in the cycle en falls still counts, because tready was already high.
- Arithmetic: expected wraps modulo 2^AXIS_WIDTH, so all-ones followed by 0 is a match. beat_count and err_count saturate at all-ones; no wrap.
- clr: has priority over a same-cycle hs for beat_count, err_count, error and first_err_data (all cleared; that beat is not counted). expected, last_data and state still update from that hs.
- Latency: counters, error and last_data reflect a handshake on the next rising edge.
- ready_pattern changes take effect only on the next IDLE→ARMED transition.
- Async reset mid-transfer: everything returns to reset values immediately, including tready=0. The in-flight beat is not accepted.

Decomposition:
- Shared package: state encoding constants (IDLE, ARMED, CHECK) and a default pattern constant (all-ones).
- One natural sub-module: sat_counter (CNT_WIDTH, inc, clr, async active-low reset), instantiated twice for beat_count and err_count.
- Pattern rotator and checker FSM remain in the top module.

Test Plan:
- Reset/idle: hold reset_n=0, then release with en=0 and tvalid=1 → tready stays 0 and all outputs stay 0 for 20 cycles.
- Clean stream: ready_pattern=8'hFF, source sends 5,6,…,104 → beat_count=100, err_count=0, error=0, last_data=104, locked=1.
- Backpressure: ready_pattern=8'b0101_0101, tvalid held high, 16 beats → tready alternates 1/0 each cycle; 16 beats take 32 cycles; no errors. ready_pattern=0 → behaves as 8'hFF.
- Mismatch/resync: send 10,11,13,14,20 → err_count=2, error=1, first_err_data=13, final expected=21.
- Wrap and saturation:
  - AXIS_WIDTH=32, send FFFF_FFFE, FFFF_FFFF, 0, 1 → err_count=0.
  - CNT_WIDTH=4, send 20 beats → beat_count holds at 15.
- Simultaneous clr+hs and en drop: assert clr on the cycle of a handshake → beat_count=0 and that beat is uncounted. The next beat is checked against it and beat_count becomes 1. Drop en with tvalid high → at most one further beat accepted, then tready=0 and locked=0.

Source files
------------

// File: rtl/axis_sink_checker_pkg.sv
// Shared constants for the AXI-Stream sink checker: FSM encoding and the
// default backpressure pattern.
package axis_sink_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_CHECK = 2'd2;

  localparam int unsigned PAT_MAX_WIDTH = 64;
  // An all-ones pattern keeps tready high every cycle.
  localparam logic [PAT_MAX_WIDTH-1:0] PAT_DEFAULT = '1;

endpackage

// File: rtl/axis_sink_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset.
module axis_sink_checker_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/axis_sink_checker.sv
// AXI-Stream sink: drives a rotating tready pattern and checks that accepted
// data increments by one per beat, reporting counts and the first bad word.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | tready low, waiting for en
//   ST_ARMED | pattern running, waiting for first beat to seed expected value
//   ST_CHECK | pattern running, every accepted beat compared with expected
module axis_sink_checker
  import axis_sink_checker_pkg::*;
#(
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PAT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PAT_WIDTH-1:0]  ready_pattern,
  input  logic                  s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  error,
  output logic [AXIS_WIDTH-1:0] first_err_data,
  output logic [AXIS_WIDTH-1:0] last_data,
  output logic                  locked
);

  state_t                state_q, state_d;
  logic [PAT_WIDTH-1:0]  pat_q, pat_d;
  logic                  tready_q, tready_d;
  logic [AXIS_WIDTH-1:0] exp_q, exp_d;
  logic [AXIS_WIDTH-1:0] last_q, last_d;
  logic                  error_q, error_d;
  logic [AXIS_WIDTH-1:0] ferr_q, ferr_d;

  logic                  hs;
  logic                  mismatch;
  logic [PAT_WIDTH-1:0]  pat_init;

  assign hs       = s_axis_tvalid & tready_q;
  assign mismatch = hs && (state_q == ST_CHECK) && (s_axis_tdata != exp_q);
  // A zero pattern would never assert tready, so it is promoted to all-ones.
  assign pat_init = (ready_pattern == '0) ? PAT_DEFAULT[PAT_WIDTH-1:0] : ready_pattern;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    tready_d = tready_q;
    exp_d    = exp_q;
    last_d   = last_q;
    error_d  = error_q;
    ferr_d   = ferr_q;

    case (state_q)
      ST_IDLE: begin
        tready_d = 1'b0;
        if (en) begin
          state_d  = ST_ARMED;
          tready_d = pat_init[0];
          pat_d    = {pat_init[0], pat_init[PAT_WIDTH-1:1]};
        end
      end
      ST_ARMED, ST_CHECK: begin
        if (!en) begin
          state_d  = ST_IDLE;
          tready_d = 1'b0;
        end else begin
          tready_d = pat_q[0];
          pat_d    = {pat_q[0], pat_q[PAT_WIDTH-1:1]};
          if ((state_q == ST_ARMED) && hs) begin
            state_d = ST_CHECK;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tready_d = 1'b0;
      end
    endcase

    // Expected value always resyncs to the received word, good or bad.
    if (hs) begin
      exp_d  = s_axis_tdata + AXIS_WIDTH'(1);
      last_d = s_axis_tdata;
    end

    if (clr) begin
      error_d = 1'b0;
      ferr_d  = '0;
    end else if (mismatch && !error_q) begin
      error_d = 1'b1;
      ferr_d  = s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      tready_q <= 1'b0;
      exp_q    <= '0;
      last_q   <= '0;
      error_q  <= 1'b0;
      ferr_q   <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      tready_q <= tready_d;
      exp_q    <= exp_d;
      last_q   <= last_d;
      error_q  <= error_d;
      ferr_q   <= ferr_d;
    end
  end

  axis_sink_checker_sat_counter #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (clr),
    .inc_i   (hs),
    .count_o (beat_count)
  );

  axis_sink_checker_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (clr),
    .inc_i   (mismatch),
    .count_o (err_count)
  );

  assign s_axis_tready  = tready_q;
  assign error          = error_q;
  assign first_err_data = ferr_q;
  assign last_data      = last_q;
  assign locked         = (state_q == ST_CHECK);

endmodule

// File: tb/tb_axis_sink_checker.sv
// Scoreboard bench for axis_sink_checker: a driver issues beats and pushes the
// reference model's expected outputs; a negedge monitor pops and compares.
module tb_axis_sink_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  ready_pattern = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = 32'h0;

  logic        s_axis_tready;
  logic [15:0] beat_count, err_count;
  logic        error, locked;
  logic [31:0] first_err_data, last_data;

  logic        b_tready, b_error, b_locked;
  logic [3:0]  b_beat, b_err;
  logic [31:0] b_ferr, b_last;

  axis_sink_checker #(.AXIS_WIDTH(32), .CNT_WIDTH(16), .PAT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .ready_pattern(ready_pattern),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .beat_count(beat_count), .err_count(err_count), .error(error),
    .first_err_data(first_err_data), .last_data(last_data), .locked(locked));

  // Narrow-counter instance shares all inputs to exercise saturation.
  axis_sink_checker #(.AXIS_WIDTH(32), .CNT_WIDTH(4), .PAT_WIDTH(8)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .ready_pattern(ready_pattern),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(b_tready),
    .beat_count(b_beat), .err_count(b_err), .error(b_error),
    .first_err_data(b_ferr), .last_data(b_last), .locked(b_locked));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  typedef struct {
    logic [31:0] last;
    int          beats;
    int          errs;
    bit          err;
    logic [31:0] ferr;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: the sequence rules expressed directly.
  bit          m_first = 1'b1;
  logic [31:0] m_exp = 32'h0;
  logic [31:0] m_last = 32'h0;
  logic [31:0] m_ferr = 32'h0;
  int          m_beats = 0;
  int          m_errs = 0;
  bit          m_error = 1'b0;

  task automatic model_reset();
    m_first = 1'b1; m_exp = 32'h0; m_last = 32'h0; m_ferr = 32'h0;
    m_beats = 0; m_errs = 0; m_error = 1'b0;
  endtask

  task automatic model_clr();
    m_beats = 0; m_errs = 0; m_error = 1'b0; m_ferr = 32'h0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit c);
    exp_t e;
    bit   mism;
    mism    = !m_first && (d != m_exp);
    m_first = 1'b0;
    if (c) begin
      model_clr();
    end else begin
      m_beats++;
      if (mism) begin
        m_errs++;
        if (!m_error) begin
          m_error = 1'b1;
          m_ferr  = d;
        end
      end
    end
    m_exp  = d + 32'd1;
    m_last = d;
    e.last = m_last; e.beats = m_beats; e.errs = m_errs; e.err = m_error; e.ferr = m_ferr;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs seen at a negedge reflect the handshake seen one negedge earlier.
  bit   pend = 1'b0;
  bit   win = 1'b0;
  bit   win_s[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          mon_e = sb_q.pop_front();
          chk("beat_count", beat_count, 64'(sat(mon_e.beats, 16)));
          chk("err_count", err_count, 64'(sat(mon_e.errs, 16)));
          chk("error", error, mon_e.err);
          chk("first_err_data", first_err_data, mon_e.ferr);
          chk("last_data", last_data, mon_e.last);
          chk("beat_count_w4", b_beat, 64'(sat(mon_e.beats, 4)));
          chk("err_count_w4", b_err, 64'(sat(mon_e.errs, 4)));
        end
      end
      pend = s_axis_tvalid && s_axis_tready;
      if (win) win_s.push_back(s_axis_tready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit c);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    clr           = c;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) begin
        model_beat(d, c);
        done = 1'b1;
      end else begin
        n++;
        if (n > 64) begin
          chk("beat_timeout", 64'(n), 64'd64);
          done = 1'b1;
        end
      end
      step();
    end
    s_axis_tvalid = 1'b0;
    clr           = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    model_clr();
    step();
    clr = 1'b0;
  endtask

  task automatic arm(input logic [7:0] pat);
    ready_pattern = pat;
    en            = 1'b1;
    m_first       = 1'b1;
    step();
  endtask

  task automatic disarm();
    en            = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          t0, bad, acc;
    logic [31:0] v, d;
    bit          c;

    // Reset and idle with tvalid asserted.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h1234;
    #23;
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_tready", s_axis_tready, 64'd0);
      chk("idle_outputs_zero",
          {beat_count, err_count, error, locked, first_err_data, last_data}, 64'd0);
    end
    s_axis_tvalid = 1'b0;
    step();

    // Clean incrementing stream.
    arm(8'hFF);
    for (int i = 5; i <= 104; i++) send_beat(32'(i), 1'b0);
    chk("clean_beats", beat_count, 64'd100);
    chk("clean_errs", err_count, 64'd0);
    chk("clean_error", error, 64'd0);
    chk("clean_last", last_data, 64'd104);
    chk("clean_locked", locked, 64'd1);
    chk("sat_w4_beats", b_beat, 64'd15);
    disarm();
    chk("disarm_locked", locked, 64'd0);
    chk("disarm_tready", s_axis_tready, 64'd0);
    pulse_clr();
    chk("clr_beats", beat_count, 64'd0);

    // Alternating backpressure with tvalid held high.
    t0 = cyc;
    arm(8'b0101_0101);
    win_s.delete();
    win = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(32'(200 + i), 1'b0);
    win = 1'b0;
    chk("bp_cycles", 64'(cyc - t0), 64'd32);
    bad = 0;
    foreach (win_s[i]) if (win_s[i] != ((i % 2) == 0)) bad++;
    chk("bp_alternate", 64'(bad), 64'd0);
    chk("bp_samples_enough", 64'(win_s.size() >= 16), 64'd1);
    chk("bp_errs", err_count, 64'd0);
    disarm();

    // Zero pattern acts as all-ones.
    t0 = cyc;
    arm(8'h00);
    for (int i = 0; i < 10; i++) send_beat(32'(300 + i), 1'b0);
    chk("zero_pat_cycles", 64'(cyc - t0), 64'd11);
    disarm();

    // Mismatch and resync.
    pulse_clr();
    arm(8'hFF);
    send_beat(32'd10, 1'b0);
    send_beat(32'd11, 1'b0);
    send_beat(32'd13, 1'b0);
    send_beat(32'd14, 1'b0);
    send_beat(32'd20, 1'b0);
    chk("mm_errs", err_count, 64'd2);
    chk("mm_error", error, 64'd1);
    chk("mm_first", first_err_data, 64'd13);
    send_beat(32'd21, 1'b0);
    chk("mm_resync_21", err_count, 64'd2);
    disarm();

    // Data wrap.
    pulse_clr();
    arm(8'hFF);
    send_beat(32'hFFFF_FFFE, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0000, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    chk("wrap_errs", err_count, 64'd0);
    chk("wrap_last", last_data, 64'd1);
    disarm();

    // Randomised stream: gaps, corruptions, clr on beats, re-arming.
    pulse_clr();
    arm(8'($urandom_range(1, 255)));
    v = $urandom;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        disarm();
        arm(8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) step();
      d = ($urandom_range(0, 9) == 0) ? 32'($urandom) : v;
      c = ($urandom_range(0, 29) == 0);
      send_beat(d, c);
      v = d + 32'd1;
    end
    disarm();

    // clr on the same cycle as a handshake.
    arm(8'hFF);
    send_beat(32'd500, 1'b0);
    send_beat(32'd501, 1'b1);
    chk("clrhs_beats", beat_count, 64'd0);
    send_beat(32'd502, 1'b0);
    chk("clrhs_next_beats", beat_count, 64'd1);
    chk("clrhs_next_errs", err_count, 64'd0);

    // Drop en with tvalid still high.
    acc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd503;
    en            = 1'b0;
    @(negedge clk);
    if (s_axis_tready) begin
      model_beat(32'd503, 1'b0);
      acc++;
    end
    step();
    s_axis_tdata = 32'd504;
    repeat (3) begin
      @(negedge clk);
      if (s_axis_tready) acc++;
    end
    chk("endrop_at_most_one", 64'(acc <= 1), 64'd1);
    chk("endrop_tready", s_axis_tready, 64'd0);
    chk("endrop_locked", locked, 64'd0);
    s_axis_tvalid = 1'b0;
    step();

    // Async reset in the middle of a transfer.
    arm(8'hFF);
    step();
    step();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd600;
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_tready", s_axis_tready, 64'd0);
    chk("areset_outputs_zero",
        {beat_count, err_count, error, locked, first_err_data, last_data}, 64'd0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    en            = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    chk("post_reset_beats", beat_count, 64'd0);
    chk("post_reset_last", last_data, 64'd0);

    step();
    step();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
